// File: rtl/md_alu_pkg.sv
// rtl/md_alu_pkg.sv - shared operation codes and engine state encoding for md_alu
package md_alu_pkg;

    localparam int OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 5'd0,
        OP_OR    = 5'd1,
        OP_ADD   = 5'd2,
        OP_SUB   = 5'd3,
        OP_NOR   = 5'd4,
        OP_XOR   = 5'd5,
        OP_SLL   = 5'd6,
        OP_SRL   = 5'd7,
        OP_SRA   = 5'd8,
        OP_SLT   = 5'd9,
        OP_SLTU  = 5'd10,
        OP_LUI   = 5'd11,
        OP_MULT  = 5'd12,
        OP_MULTU = 5'd13,
        OP_DIV   = 5'd14,
        OP_DIVU  = 5'd15,
        OP_MTHI  = 5'd16,
        OP_MTLO  = 5'd17,
        OP_MFHI  = 5'd18,
        OP_MFLO  = 5'd19
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

endpackage

// File: rtl/md_iter.sv
// rtl/md_iter.sv - iterative radix-2 multiply / restoring divide engine
// Ports: clk, reset_n (async active-low); start_mul/start_div/is_signed with
// op_a/op_b operands, sampled only in IDLE; busy (state != IDLE); done (FIX
// cycle, hi_out/lo_out valid for the parent to capture on that edge).
module md_iter
    import md_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_mul,
    input  logic             start_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opb_q;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   dvd_q;      // raw dividend, returned in HI on divide-by-zero
    logic               neg_lo_q;   // product or quotient must be negated
    logic               neg_hi_q;   // remainder must be negated
    logic               dz_q;
    logic               is_div_q;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_d;
    logic [WIDTH:0]     rem_sh, diff;
    logic [2*WIDTH-1:0] div_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem;

    assign mag_a = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign mag_b = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

    // Add multiplicand into the upper half when the current LSB is set, then shift right.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    assign mul_d   = {mul_sum, acc_q[WIDTH-1:1]};

    // Shift next dividend bit into the remainder; diff MSB set means remainder < divisor.
    assign rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, opb_q};
    assign div_d  = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_lo_q ? -acc_q : acc_q;
    assign quo      = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem      = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        hi_out = prod_fix[2*WIDTH-1:WIDTH];
        lo_out = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (dz_q) begin
                hi_out = dvd_q;
                lo_out = '1;
            end else begin
                hi_out = rem;
                lo_out = quo;
            end
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_FIX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            dvd_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_mul || start_div) begin
                        state_q  <= start_mul ? ST_MUL : ST_DIV;
                        cnt_q    <= '0;
                        acc_q    <= {{WIDTH{1'b0}}, mag_a};
                        opb_q    <= mag_b;
                        dvd_q    <= op_a;
                        neg_lo_q <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        neg_hi_q <= is_signed && op_a[WIDTH-1];
                        dz_q     <= (op_b == '0);
                        is_div_q <= start_div && !start_mul;
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_q <= (state_q == ST_MUL) ? mul_d : div_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= ST_FIX;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/md_alu.sv
// rtl/md_alu.sv - execute-stage ALU with iterative multiply/divide and HI/LO registers
// Ports: clk, reset_n (async active-low); op_valid/alu_ctrl issue an operation
// on data_a/data_b/shamt; result/zero are combinational; busy flags the
// multiply/divide engine; hi/lo are the architectural HI/LO registers.
module md_alu
    import md_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               op_valid,
    input  logic [OP_W-1:0]    alu_ctrl,
    input  logic [WIDTH-1:0]   data_a,
    input  logic [WIDTH-1:0]   data_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               busy,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic             md_done;
    logic             accept;
    logic             start_mul, start_div, is_signed;

    // Sequential ops are dropped while the engine is occupied.
    assign accept    = op_valid && !busy;
    assign start_mul = accept && (alu_ctrl == OP_MULT || alu_ctrl == OP_MULTU);
    assign start_div = accept && (alu_ctrl == OP_DIV  || alu_ctrl == OP_DIVU);
    assign is_signed = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_DIV);

    md_iter #(.WIDTH(WIDTH)) u_md_iter (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_mul (start_mul),
        .start_div (start_div),
        .is_signed (is_signed),
        .op_a      (data_a),
        .op_b      (data_b),
        .busy      (busy),
        .done      (md_done),
        .hi_out    (md_hi),
        .lo_out    (md_lo)
    );

    // done only occurs while busy, so it never collides with an accepted MTHI/MTLO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (md_done) begin
            hi_q <= md_hi;
            lo_q <= md_lo;
        end else if (accept) begin
            if (alu_ctrl == OP_MTHI) hi_q <= data_a;
            if (alu_ctrl == OP_MTLO) lo_q <= data_a;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

    always_comb begin
        result = '0;
        case (alu_ctrl)
            OP_AND:  result = data_a & data_b;
            OP_OR:   result = data_a | data_b;
            OP_ADD:  result = data_a + data_b;
            OP_SUB:  result = data_a - data_b;
            OP_NOR:  result = ~(data_a | data_b);
            OP_XOR:  result = data_a ^ data_b;
            OP_SLL:  result = data_b << shamt;
            OP_SRL:  result = data_b >> shamt;
            OP_SRA:  result = $signed(data_b) >>> shamt;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(data_a) < $signed(data_b))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (data_a < data_b)};
            OP_LUI:  result = {data_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_MFHI: result = hi_q;
            OP_MFLO: result = lo_q;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: tb/tb_md_alu.sv
// tb/tb_md_alu.sv - directed self-checking bench for md_alu at WIDTH 32 and 16
module tb_md_alu;
    import md_alu_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        op_valid;
    logic [4:0]  alu_ctrl;
    logic [31:0] data_a, data_b;
    logic [4:0]  shamt;
    logic [31:0] result, hi, lo;
    logic        zero, busy;

    logic        op_valid16;
    logic [4:0]  alu_ctrl16;
    logic [15:0] data_a16, data_b16;
    logic [3:0]  shamt16;
    logic [15:0] result16, hi16, lo16;
    logic        zero16, busy16;

    int total = 0;
    int bad   = 0;

    md_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .alu_ctrl(alu_ctrl),
        .data_a(data_a), .data_b(data_b), .shamt(shamt),
        .result(result), .zero(zero), .busy(busy), .hi(hi), .lo(lo)
    );

    md_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid16), .alu_ctrl(alu_ctrl16),
        .data_a(data_a16), .data_b(data_b16), .shamt(shamt16),
        .result(result16), .zero(zero16), .busy(busy16), .hi(hi16), .lo(lo16)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] r;
        logic        z;
    } vec_t;

    vec_t vecs [15];

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1; alu_ctrl = op; data_a = a; data_b = b;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int cyc;
        total++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_state: hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy);
        end
        @(negedge clk); reset_n = 1'b1;
        issue(OP_MTHI, 32'hAAAA, 32'h0);
        issue(OP_MTLO, 32'h5555, 32'h0);
        issue(OP_MULT, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if (hi !== 32'h0) begin bad++; $display("FAIL midreset_hi: got %h want 0", hi); end
        total++;
        if (lo !== 32'h0) begin bad++; $display("FAIL midreset_lo: got %h want 0", lo); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
        @(negedge clk); reset_n = 1'b1;
        issue(OP_MULTU, 32'd3, 32'd5);
        wait_idle(cyc);
        total++;
        if (cyc != 33) begin bad++; $display("FAIL multu_busy: got %0d want 33", cyc); end
        total++;
        if (lo !== 32'd15 || hi !== 32'd0) begin
            bad++; $display("FAIL multu_3x5: hi=%h lo=%h want 0 f", hi, lo);
        end
    endtask

    task automatic test_mult();
        int cyc;
        issue(OP_MULT, 32'hFFFFFFFF, 32'd2);
        wait_idle(cyc);
        total++;
        if (cyc != 33) begin bad++; $display("FAIL mult_busy: got %0d want 33", cyc); end
        total++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
            bad++; $display("FAIL mult_m1x2: hi=%h lo=%h want ffffffff fffffffe", hi, lo);
        end
        issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
        wait_idle(cyc);
        total++;
        if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin
            bad++; $display("FAIL multu_big: hi=%h lo=%h want 1 fffffffe", hi, lo);
        end
    endtask

    task automatic test_div();
        int cyc;
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle(cyc);
        total++;
        if (cyc != 33) begin bad++; $display("FAIL div_busy: got %0d want 33", cyc); end
        total++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            bad++; $display("FAIL div_m7_2: hi=%h lo=%h want ffffffff fffffffd", hi, lo);
        end
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(cyc);
        total++;
        if (lo !== 32'h80000000 || hi !== 32'h0) begin
            bad++; $display("FAIL div_min_m1: hi=%h lo=%h want 0 80000000", hi, lo);
        end
        issue(OP_DIVU, 32'd9, 32'd0);
        wait_idle(cyc);
        total++;
        if (lo !== 32'hFFFFFFFF || hi !== 32'd9) begin
            bad++; $display("FAIL divu_by0: hi=%h lo=%h want 9 ffffffff", hi, lo);
        end
        issue(OP_DIV, 32'hFFFFFFF9, 32'd0);
        wait_idle(cyc);
        total++;
        if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF9) begin
            bad++; $display("FAIL div_by0_signed: hi=%h lo=%h want fffffff9 ffffffff", hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        issue(OP_DIV, 32'd20, 32'd3);
        issue(OP_DIV, 32'd100, 32'd7);
        alu_ctrl = OP_MFHI;
        #1;
        total++;
        if (result !== 32'hFFFFFFF9) begin
            bad++; $display("FAIL mfhi_busy: got %h want fffffff9", result);
        end
        issue(OP_MTLO, 32'h1234, 32'h0);
        wait_idle(cyc);
        total++;
        if (hi !== 32'd2 || lo !== 32'd6) begin
            bad++; $display("FAIL drop_busy: hi=%h lo=%h want 2 6", hi, lo);
        end
        issue(OP_MTLO, 32'h1234, 32'h0);
        total++;
        if (lo !== 32'h1234) begin bad++; $display("FAIL mtlo_idle: got %h want 1234", lo); end
        alu_ctrl = OP_MFLO;
        #1;
        total++;
        if (result !== 32'h1234) begin bad++; $display("FAIL mflo: got %h want 1234", result); end
        // Immediately after completion a new MD op must be accepted.
        issue(OP_MULTU, 32'd6, 32'd7);
        wait_idle(cyc);
        issue(OP_MULTU, 32'd11, 32'd11);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: busy=%b want 1", busy); end
        wait_idle(cyc);
        total++;
        if (lo !== 32'd121 || hi !== 32'd0) begin
            bad++; $display("FAIL b2b_result: hi=%h lo=%h want 0 79", hi, lo);
        end
    endtask

    task automatic test_comb();
        vecs[0]  = '{OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd0,  32'h00F0_1200, 1'b0};
        vecs[1]  = '{OP_OR,   32'hF000_0001, 32'h0000_0F00, 5'd0,  32'hF000_0F01, 1'b0};
        vecs[2]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1};
        vecs[3]  = '{OP_SUB,  32'd5,         32'd5,         5'd0,  32'h0000_0000, 1'b1};
        vecs[4]  = '{OP_NOR,  32'h0,         32'h0,         5'd0,  32'hFFFF_FFFF, 1'b0};
        vecs[5]  = '{OP_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 5'd0,  32'h5555_5555, 1'b0};
        vecs[6]  = '{OP_SLL,  32'h0,         32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
        vecs[7]  = '{OP_SRL,  32'h0,         32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0};
        vecs[8]  = '{OP_SRA,  32'h0,         32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0};
        vecs[9]  = '{OP_SLT,  32'hFFFF_FFFF, 32'd1,         5'd0,  32'd1,         1'b0};
        vecs[10] = '{OP_SLTU, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0,         1'b1};
        vecs[11] = '{OP_LUI,  32'h0,         32'h0000_ABCD, 5'd0,  32'hABCD_0000, 1'b0};
        vecs[12] = '{5'd25,   32'h1234_5678, 32'h9ABC_DEF0, 5'd3,  32'd0,         1'b1};
        vecs[13] = '{OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3,  32'd0,         1'b1};
        vecs[14] = '{OP_SUB,  32'd3,         32'd5,         5'd0,  32'hFFFF_FFFE, 1'b0};
        @(negedge clk);
        op_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            alu_ctrl = vecs[i].op; data_a = vecs[i].a; data_b = vecs[i].b; shamt = vecs[i].sh;
            #1;
            total++;
            if (result !== vecs[i].r || zero !== vecs[i].z) begin
                bad++;
                $display("FAIL comb[%0d] op=%0d: result=%h zero=%b want %h %b",
                         i, vecs[i].op, result, zero, vecs[i].r, vecs[i].z);
            end
        end
    endtask

    task automatic test_w16();
        int cyc;
        @(negedge clk);
        op_valid16 = 1'b1; alu_ctrl16 = OP_MULTU; data_a16 = 16'hFFFF; data_b16 = 16'hFFFF;
        @(negedge clk);
        op_valid16 = 1'b0;
        cyc = 0;
        while (busy16 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        total++;
        if (cyc != 17) begin bad++; $display("FAIL w16_busy: got %0d want 17", cyc); end
        total++;
        if (hi16 !== 16'hFFFE || lo16 !== 16'h0001) begin
            bad++; $display("FAIL w16_multu: hi=%h lo=%h want fffe 0001", hi16, lo16);
        end
        alu_ctrl16 = OP_LUI; data_b16 = 16'h00AB;
        #1;
        total++;
        if (result16 !== 16'hAB00) begin bad++; $display("FAIL w16_lui: got %h want ab00", result16); end
    endtask

    initial begin
        reset_n = 1'b0;
        op_valid = 1'b0; alu_ctrl = 5'd0; data_a = '0; data_b = '0; shamt = '0;
        op_valid16 = 1'b0; alu_ctrl16 = 5'd0; data_a16 = '0; data_b16 = '0; shamt16 = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_comb();
        test_w16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
